// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the RV32I pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       regWrite;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       isLoad;
        logic       isMem;
    } stage_info_t;

    localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;
    localparam stage_info_t BUBBLE          = '0;

    // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we,
        input logic [4:0] rs
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = FWD_MEM;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stage_reg
// Description : One shadow pipeline entry with hold / clear / load controls
//               and asynchronous active-low reset. Hold beats clear beats load.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_clear,
    input  logic        i_load,
    input  stage_info_t i_d,
    output stage_info_t o_q
);

    stage_info_t r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= BUBBLE;
        end else if (i_hold) begin
            r_q <= r_q;
        end else if (i_clear) begin
            r_q <= BUBBLE;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Forwarding, load-use stall, branch flush and stall counting
//               for the five-stage RV32I core. Define HAZARD_MEM_WAIT_EN to
//               add data-memory wait handling (RUN/WAIT state machine).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdD,
    input  logic             regWriteD,
    input  logic [1:0]       resultSrcD,
    input  logic             branchTakenE,
    input  logic             memReadyM,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic             stallE,
    output logic             stallM,
    output logic             flushW,
    output logic [CNT_W-1:0] stallCount
);

    stage_info_t      w_d_info;
    stage_info_t      w_e;
    stage_info_t      w_m;
    stage_info_t      w_w;
    logic             w_lw_stall;
    logic             w_wait;
    logic [CNT_W-1:0] r_stall_cnt;

    always_comb begin
        w_d_info          = BUBBLE;
        w_d_info.rd       = rdD;
        w_d_info.regWrite = regWriteD;
        w_d_info.rs1      = rs1D;
        w_d_info.rs2      = rs2D;
        w_d_info.isLoad   = (resultSrcD == RESULT_SRC_LOAD);
        // Only loads are visible from decode, so they are the memory ops tracked.
        w_d_info.isMem    = (resultSrcD == RESULT_SRC_LOAD);
    end

`ifdef HAZARD_MEM_WAIT_EN
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_m.isMem && !memReadyM) w_state_nxt = S_WAIT;
            S_WAIT:  if (memReadyM)               w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign w_wait = !memReadyM && (w_m.isMem || (r_state == S_WAIT));
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = memReadyM;
    assign w_wait             = 1'b0;
`endif

    assign w_lw_stall = w_e.isLoad && (w_e.rd != 5'd0) &&
                        ((w_e.rd == rs1D) || (w_e.rd == rs2D));

    assign forwardAE = fwd_select(w_m.rd, w_m.regWrite, w_w.rd, w_w.regWrite, w_e.rs1);
    assign forwardBE = fwd_select(w_m.rd, w_m.regWrite, w_w.rd, w_w.regWrite, w_e.rs2);

    // A memory wait freezes everything; a branch still pending is taken on release.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushW = 1'b0;
        if (w_wait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallF = w_lw_stall && !branchTakenE;
            stallD = w_lw_stall && !branchTakenE;
            flushD = branchTakenE;
            flushE = w_lw_stall || branchTakenE;
        end
    end

    hazard_stage_reg u_stage_e (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_wait),
        .i_clear (flushE),
        .i_load  (1'b1),
        .i_d     (w_d_info),
        .o_q     (w_e)
    );

    hazard_stage_reg u_stage_m (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_wait),
        .i_clear (1'b0),
        .i_load  (1'b1),
        .i_d     (w_e),
        .o_q     (w_m)
    );

    hazard_stage_reg u_stage_w (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (1'b0),
        .i_clear (w_wait),
        .i_load  (1'b1),
        .i_d     (w_m),
        .o_q     (w_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stallF) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stallCount = r_stall_cnt;

    logic w_unused_fields;
    assign w_unused_fields = ^{w_w.rs1, w_w.rs2, w_w.isLoad, w_w.isMem,
                               w_m.rs1, w_m.rs2, w_m.isLoad, w_m.isMem, w_e.isMem};

endmodule
`default_nettype wire
